// File: rtl/uart_rx_tx_if.sv
// Byte-side handshake bundle of the uart_rx_tx transceiver.
//   rx_data  [7:0] : last correctly framed received byte
//   rx_valid       : one-cycle pulse when rx_data updates
//   tx_data  [7:0] : byte offered for transmission
//   tx_valid       : transmit request
//   tx_ready       : transmitter idle and able to accept a byte
// master = byte-oriented controller, slave = transceiver.
interface uart_rx_tx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

  modport slave (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/uart_rx_tx.sv
// Byte-level 8N1 UART transceiver: independent receiver and transmitter
// sharing clock, synchronous active-high reset and baud divider.
//   clk      : system clock, CLOCK_FREQ Hz
//   rst      : synchronous active-high reset
//   rx       : asynchronous serial receive line, idle high
//   start_rx : receiver enable, a new frame may only start while high
//   tx       : serial transmit line, idle high (registered)
//   bus      : byte handshake (rx_data/rx_valid out, tx_data/tx_valid in,
//              tx_ready out), all outputs registered
module uart_rx_tx #(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         start_rx,
  output logic         tx,
  uart_rx_tx_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic             r_rx_meta;
  logic             r_rx_s;
  state_t           r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_idx;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receive FSM: confirm start at half-bit, then sample each bit at mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        ST_IDLE: begin
          r_rx_cnt <= '0;
          if (start_rx && !r_rx_s) begin
            r_rx_state <= ST_START;
          end
        end

        ST_START: begin
          if (r_rx_cnt == CNT_HALF) begin
            r_rx_cnt <= '0;
            r_rx_idx <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            r_rx_state <= r_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt             <= '0;
            r_rx_shift[r_rx_idx] <= r_rx_s;
            if (r_rx_idx == 3'd7) begin
              r_rx_state <= ST_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (r_rx_cnt == CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= ST_IDLE;
            // A low stop bit is a framing error: drop the byte silently.
            if (r_rx_s) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end

        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  state_t           r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_idx;
  logic [7:0]       r_tx_shift;
  logic             r_tx;
  logic             r_tx_ready;

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          r_tx       <= 1'b1;
          r_tx_ready <= 1'b1;
          r_tx_cnt   <= '0;
          if (bus.tx_valid && r_tx_ready) begin
            r_tx_shift <= bus.tx_data;
            r_tx       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_state <= ST_START;
          end
        end

        ST_START: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= ST_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= ST_STOP;
            end else begin
              // Bit 1 of the current shift value is the next bit to send.
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx       <= r_tx_shift[1];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (r_tx_cnt == CNT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_state <= ST_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_tx       <= 1'b1;
          r_tx_ready <= 1'b1;
          r_tx_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx           = r_tx;
  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_uart_rx_tx.sv
// Directed self-checking bench for uart_rx_tx at CLKS_PER_BIT=10, HALF_BIT=5.
module tb_uart_rx_tx;

  logic clk = 1'b0;
  logic rst;
  logic rx_drv;
  logic lb;
  logic start_rx;
  logic tx;
  logic w_line;

  uart_rx_tx_if bus ();

  assign w_line = lb ? tx : rx_drv;

  uart_rx_tx #(
    .BAUD_RATE (100000),
    .CLOCK_FREQ(1000000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (w_line),
    .start_rx(start_rx),
    .tx      (tx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc;
  int         pulses;
  int         first_pulse;
  logic [7:0] last_rx;
  int         w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clr();
    cyc         = 0;
    pulses      = 0;
    first_pulse = -1;
    last_rx     = 8'hxx;
  endtask

  // Advance one clock, sample 1ns after the edge and record rx_valid pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rx_valid === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
      last_rx = bus.rx_data;
    end
  endtask

  // Drive one frame on rx (10 cycles per bit), then 10 idle cycles.
  task automatic rx_frame(input logic [7:0] d, input logic stop, input int drop_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    mon_clr();
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 10; k++) begin
        if (b * 10 + k == drop_at) start_rx = 1'b0;
        rx_drv = bits[b];
        tick();
      end
    end
    rx_drv = 1'b1;
    repeat (10) tick();
  endtask

  // Hand one byte to the transmitter and check the line at every mid-bit.
  task automatic tx_frame(input logic [7:0] d, output int wait_cyc);
    logic [9:0] bits;
    int low;
    bits     = {1'b1, d, 1'b0};
    wait_cyc = 0;
    while (bus.tx_ready !== 1'b1 && wait_cyc < 300) begin
      tick();
      wait_cyc++;
    end
    check("tx_ready_timeout", 32'(wait_cyc >= 300), 32'd0);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~d;
    low = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.tx_ready === 1'b0) low++;
      if (c == 0) check("tx_fall", 32'(tx), 32'd0);
      if (c % 10 == 5) check($sformatf("tx_bit%0d_%02h", c / 10, d), 32'(tx), 32'(bits[c / 10]));
      tick();
    end
    check("tx_ready_low_cycles", 32'(low), 32'd100);
    check("tx_ready_back", 32'(bus.tx_ready), 32'd1);
  endtask

  logic [7:0] lb_bytes [4];

  initial begin
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hFF;
    lb_bytes[2] = 8'h5A;
    lb_bytes[3] = 8'h96;

    rst          = 1'b1;
    rx_drv       = 1'b1;
    lb           = 1'b0;
    start_rx     = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    mon_clr();

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    repeat (5) tick();

    // Receive A5: one pulse, 98 cycles after the start edge
    rx_frame(8'hA5, 1'b1, -1);
    check("rx_a5_pulses", 32'(pulses), 32'd1);
    check("rx_a5_data", 32'(last_rx), 32'hA5);
    check("rx_a5_latency", 32'(first_pulse), 32'd98);
    check("rx_a5_hold", 32'(bus.rx_data), 32'hA5);

    // 3-cycle low glitch
    mon_clr();
    rx_drv = 1'b0;
    repeat (3) tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    check("rx_glitch_pulses", 32'(pulses), 32'd0);

    // Receiver gated off
    start_rx = 1'b0;
    rx_frame(8'h3C, 1'b1, -1);
    start_rx = 1'b1;
    check("rx_gated_pulses", 32'(pulses), 32'd0);
    check("rx_gated_data", 32'(bus.rx_data), 32'hA5);

    // Framing error
    rx_frame(8'h55, 1'b0, -1);
    check("rx_frame_err_pulses", 32'(pulses), 32'd0);
    check("rx_frame_err_data", 32'(bus.rx_data), 32'hA5);

    // start_rx dropped mid-frame: frame still completes
    rx_frame(8'h5A, 1'b1, 30);
    start_rx = 1'b1;
    check("rx_drop_pulses", 32'(pulses), 32'd1);
    check("rx_drop_data", 32'(last_rx), 32'h5A);
    check("rx_drop_latency", 32'(first_pulse), 32'd98);

    // Transmit 01 then AA back-to-back
    mon_clr();
    tx_frame(8'h01, w);
    tx_frame(8'hAA, w);
    check("tx_b2b_wait", 32'(w), 32'd0);
    check("tx_no_rx_pulse", 32'(pulses), 32'd0);

    // Loopback
    lb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mon_clr();
      tx_frame(lb_bytes[i], w);
      check($sformatf("lb_pulses_%02h", lb_bytes[i]), 32'(pulses), 32'd1);
      check($sformatf("lb_data_%02h", lb_bytes[i]), 32'(last_rx), 32'(lb_bytes[i]));
    end

    // Reset in the middle of a looped-back transmission
    mon_clr();
    bus.tx_data  = 8'hC3;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (45) tick();
    check("mid_tx_busy", 32'(bus.tx_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("mid_rst_rx_data", 32'(bus.rx_data), 32'h00);
    rst = 1'b0;
    mon_clr();
    repeat (150) tick();
    check("mid_rst_no_pulse", 32'(pulses), 32'd0);
    check("mid_rst_tx_idle", 32'(tx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
